cam_config_seq: RTL and testbench

Camera register-initialisation sequencer sitting directly upstream of the SCCB master. After reset it waits a power-up delay, then walks an internal register table, issuing one 3-phase SCCB write per entry. It drives the master's start/write/stop command pins and waits for each transaction to finish. It flags completion to the capture path and can be re-triggered at run time.

---
 rtl/cam_config_seq.sv | 166 ++++++++++++++++
 tb/tb_cam_config_seq.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cam_config_seq.sv
// cam_config_seq: power-up register-initialisation sequencer for a camera.
// Walks a register table and issues one 3-byte SCCB write per entry through
// the SCCB master command pins. It honours delay markers and flags completion.
module cam_config_seq #(
    parameter int unsigned CLK_F     = 100_000_000,
    parameter int unsigned PWRUP_CYC = CLK_F / 1000,
    parameter int unsigned DELAY_CYC = CLK_F / 100,
    parameter int unsigned GAP_CYC   = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cfg_start,
    input  logic       m_ready,
    input  logic       m_done,
    output logic       m_start,
    output logic       m_write,
    output logic       m_read,
    output logic       m_stop,
    output logic       m_restart,
    output logic [7:0] m_addr,
    output logic [7:0] m_din,
    output logic       cfg_busy,
    output logic       cfg_done,
    output logic [7:0] cfg_idx
);

    localparam int unsigned MAX_PD  = (PWRUP_CYC > DELAY_CYC) ? PWRUP_CYC : DELAY_CYC;
    localparam int unsigned MAX_CYC = (MAX_PD > GAP_CYC) ? MAX_PD : GAP_CYC;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC) + 1;

    localparam logic [15:0] ENT_END = 16'hFFFF;
    localparam logic [15:0] ENT_DLY = 16'hFFF0;

    typedef enum logic [2:0] {
        S_PWRUP,
        S_FETCH,
        S_ISSUE,
        S_BUSY,
        S_GAP,
        S_DELAY,
        S_DONE
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [1:0]         done_cnt;
    logic [15:0]        rom_entry;

    // Only writes are issued; the master ends the transfer on its own after byte 3
    assign m_read    = 1'b0;
    assign m_stop    = 1'b0;
    assign m_restart = 1'b0;

    // Register table {addr, data}; unlisted indices read as the end marker
    always_comb begin
        rom_entry = ENT_END;
        case (cfg_idx)
            8'd0:    rom_entry = 16'h1280;  // COM7 soft reset
            8'd1:    rom_entry = ENT_DLY;   // let the sensor settle
            8'd2:    rom_entry = 16'h1204;  // COM7 RGB output
            8'd3:    rom_entry = 16'h1101;  // CLKRC prescaler
            8'd4:    rom_entry = 16'h0C04;  // COM3 scaling enable
            8'd5:    rom_entry = 16'h3E19;  // COM14 pclk divider
            8'd6:    rom_entry = 16'h40D0;  // COM15 RGB565 full range
            8'd7:    rom_entry = 16'h3A04;  // TSLB
            8'd8:    rom_entry = 16'h1418;  // COM9 AGC ceiling
            8'd9:    rom_entry = ENT_END;
            default: rom_entry = ENT_END;
        endcase
    end

    // Sequencer FSM with registered master commands and status
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_PWRUP;
            cnt      <= '0;
            done_cnt <= '0;
            cfg_idx  <= '0;
            m_start  <= 1'b0;
            m_write  <= 1'b0;
            m_addr   <= '0;
            m_din    <= '0;
            cfg_busy <= 1'b1;
            cfg_done <= 1'b0;
        end else begin
            m_start <= 1'b0;
            case (state)
                S_PWRUP: begin
                    if (cnt == CNT_W'(PWRUP_CYC - 1)) begin
                        cnt     <= '0;
                        cfg_idx <= '0;
                        state   <= S_FETCH;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_FETCH: begin
                    if (rom_entry == ENT_END) begin
                        cfg_busy <= 1'b0;
                        cfg_done <= 1'b1;
                        state    <= S_DONE;
                    end else if (rom_entry == ENT_DLY) begin
                        cnt   <= '0;
                        state <= S_DELAY;
                    end else begin
                        m_addr <= rom_entry[15:8];
                        m_din  <= rom_entry[7:0];
                        state  <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (m_ready) begin
                        m_start  <= 1'b1;
                        m_write  <= 1'b1;
                        done_cnt <= '0;
                        state    <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (m_done && (done_cnt != 2'd3)) begin
                        done_cnt <= done_cnt + 2'd1;
                    end
                    // master ready is registered, so it is stale while m_start is high
                    if (!m_start && m_ready) begin
                        m_write <= 1'b0;
                        if (done_cnt == 2'd3) begin
                            cfg_idx <= cfg_idx + 8'd1;
                            cnt     <= '0;
                            state   <= S_GAP;
                        end else begin
                            state <= S_ISSUE;
                        end
                    end
                end
                S_GAP: begin
                    if (cnt == CNT_W'(GAP_CYC - 1)) begin
                        cnt   <= '0;
                        state <= S_FETCH;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_DELAY: begin
                    if (cnt == CNT_W'(DELAY_CYC - 1)) begin
                        cnt     <= '0;
                        cfg_idx <= cfg_idx + 8'd1;
                        state   <= S_FETCH;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    m_write <= 1'b0;
                    if (cfg_start) begin
                        cfg_idx  <= '0;
                        cfg_busy <= 1'b1;
                        cfg_done <= 1'b0;
                        state    <= S_FETCH;
                    end
                end
                default: state <= S_PWRUP;
            endcase
        end
    end

endmodule

// File: tb/tb_cam_config_seq.sv
// tb_cam_config_seq: SCCB master stub plus scoreboard of expected register writes.
module tb_cam_config_seq;

    localparam int unsigned PWRUP_CYC = 16;
    localparam int unsigned DELAY_CYC = 32;
    localparam int unsigned GAP_CYC   = 4;
    localparam int          BYTE_CYC  = 5;

    typedef struct {
        int         idx;
        logic [7:0] addr;
        logic [7:0] din;
        bit         after_delay;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cfg_start = 1'b0;
    logic       m_ready = 1'b1;
    logic       m_done = 1'b0;
    logic       m_start, m_write, m_read, m_stop, m_restart;
    logic [7:0] m_addr, m_din, cfg_idx;
    logic       cfg_busy, cfg_done;

    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t q[$];
    int   n_starts = 0;
    int   short_idx = -1;
    int   cyc = 0;
    int   last_end = 0;
    bit   busy = 1'b0;
    bit   chk_wr_low = 1'b0;
    int   ticks = 0;
    int   timer = 0;
    int   target = 3;

    cam_config_seq #(
        .CLK_F     (100_000_000),
        .PWRUP_CYC (PWRUP_CYC),
        .DELAY_CYC (DELAY_CYC),
        .GAP_CYC   (GAP_CYC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_start (cfg_start),
        .m_ready   (m_ready),
        .m_done    (m_done),
        .m_start   (m_start),
        .m_write   (m_write),
        .m_read    (m_read),
        .m_stop    (m_stop),
        .m_restart (m_restart),
        .m_addr    (m_addr),
        .m_din     (m_din),
        .cfg_busy  (cfg_busy),
        .cfg_done  (cfg_done),
        .cfg_idx   (cfg_idx)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Expected camera table, written out independently of the design
    function automatic logic [15:0] tb_entry(input int i);
        case (i)
            0: return 16'h1280;
            1: return 16'hFFF0;
            2: return 16'h1204;
            3: return 16'h1101;
            4: return 16'h0C04;
            5: return 16'h3E19;
            6: return 16'h40D0;
            7: return 16'h3A04;
            8: return 16'h1418;
            default: return 16'hFFFF;
        endcase
    endfunction

    task automatic push_run();
        bit          dly = 1'b0;
        logic [15:0] e;
        exp_t        x;
        for (int i = 0; i < 256; i++) begin
            e = tb_entry(i);
            if (e == 16'hFFFF) break;
            if (e == 16'hFFF0) begin
                dly = 1'b1;
                continue;
            end
            x.idx = i;
            x.addr = e[15:8];
            x.din = e[7:0];
            x.after_delay = dly;
            q.push_back(x);
            dly = 1'b0;
        end
    endtask

    // Edges until m_start is seen; also ends a pending cfg_start pulse after one edge
    task automatic wait_start(output int n);
        n = 0;
        repeat (300) begin
            @(posedge clk);
            #1;
            n++;
            cfg_start = 1'b0;
            if (m_start) break;
        end
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while (!cfg_done && k < 5000) begin
            @(negedge clk);
            k++;
        end
        if (!cfg_done) check("done_timeout", 32'(k), 32'(0));
    endtask

    task automatic wait_start_at(input int idx);
        int k;
        k = 0;
        while (!(m_start && cfg_idx == 8'(idx)) && k < 3000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 3000) check("start_timeout", 32'(k), 32'(0));
    endtask

    // SCCB master stub: 3 done ticks then ready, with scoreboard compare on each start
    always @(negedge clk) begin
        exp_t e;
        exp_t r;
        cyc++;
        m_done = 1'b0;
        if (rst) begin
            m_ready = 1'b1;
            busy = 1'b0;
            chk_wr_low = 1'b0;
        end else begin
            if (chk_wr_low) begin
                check("m_write_fall", 32'(m_write), 32'(0));
                chk_wr_low = 1'b0;
            end
            if (m_start) begin
                n_starts++;
                check("m_write_rise", 32'(m_write), 32'(1));
                target = 3;
                if (q.size() == 0) begin
                    check("unexpected_start", 32'(n_starts), 32'(0));
                end else begin
                    e = q.pop_front();
                    check("addr", 32'(m_addr), 32'(e.addr));
                    check("din", 32'(m_din), 32'(e.din));
                    check("idx", 32'(cfg_idx), 32'(e.idx));
                    if (e.idx != 0) begin
                        if (e.after_delay)
                            check("delay_gap", 32'((cyc - last_end) >= int'(DELAY_CYC + GAP_CYC)), 32'(1));
                        else
                            check("no_delay_gap", 32'((cyc - last_end) < int'(DELAY_CYC)), 32'(1));
                    end
                    if (e.idx == short_idx) begin
                        short_idx = -1;
                        target = 2;
                        r = e;
                        r.after_delay = 1'b0;
                        q.push_front(r);
                    end
                end
                m_ready = 1'b0;
                busy = 1'b1;
                ticks = 0;
                timer = 0;
            end else if (busy) begin
                if (ticks == target) begin
                    check("m_write_held", 32'(m_write), 32'(1));
                    m_ready = 1'b1;
                    busy = 1'b0;
                    last_end = cyc;
                    chk_wr_low = 1'b1;
                end else begin
                    timer++;
                    if (timer == BYTE_CYC) begin
                        timer = 0;
                        ticks++;
                        m_done = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        int n;
        int exp_n;
        repeat (3) @(negedge clk);
        check("rst_m_start", 32'(m_start), 32'(0));
        check("rst_m_write", 32'(m_write), 32'(0));
        check("rst_m_addr", 32'(m_addr), 32'(0));
        check("rst_m_din", 32'(m_din), 32'(0));
        check("rst_busy", 32'(cfg_busy), 32'(1));
        check("rst_done", 32'(cfg_done), 32'(0));
        check("rst_idx", 32'(cfg_idx), 32'(0));
        check("const_pins", 32'({m_read, m_stop, m_restart}), 32'(0));

        // Run 1: power-up sequence through the whole table
        push_run();
        exp_n = q.size();
        n_starts = 0;
        rst = 1'b0;
        wait_start(n);
        check("pwrup_latency", 32'(n), 32'(PWRUP_CYC + 2));
        wait_done();
        @(negedge clk);
        check("run1_done", 32'(cfg_done), 32'(1));
        check("run1_busy", 32'(cfg_busy), 32'(0));
        check("run1_m_write", 32'(m_write), 32'(0));
        check("run1_starts", 32'(n_starts), 32'(exp_n));
        check("run1_q_empty", 32'(q.size()), 32'(0));

        // Run 2: rerun from DONE, spurious early ready on entry 5, cfg_start ignored in BUSY
        push_run();
        exp_n = q.size() + 1;
        n_starts = 0;
        short_idx = 5;
        cfg_start = 1'b1;
        wait_start(n);
        check("rerun_latency", 32'(n), 32'(3));
        wait_start_at(3);
        repeat (3) @(negedge clk);
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        @(negedge clk);
        check("busy_start_idx", 32'(cfg_idx), 32'(3));
        check("busy_start_busy", 32'(cfg_busy), 32'(1));
        wait_done();
        @(negedge clk);
        check("run2_done", 32'(cfg_done), 32'(1));
        check("run2_starts", 32'(n_starts), 32'(exp_n));
        check("run2_q_empty", 32'(q.size()), 32'(0));

        // Run 3: asynchronous reset mid-byte, then full restart
        push_run();
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        wait_start_at(3);
        repeat (7) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_m_write", 32'(m_write), 32'(0));
        check("arst_idx", 32'(cfg_idx), 32'(0));
        check("arst_busy", 32'(cfg_busy), 32'(1));
        check("arst_done", 32'(cfg_done), 32'(0));
        q.delete();
        repeat (3) @(negedge clk);
        push_run();
        exp_n = q.size();
        n_starts = 0;
        rst = 1'b0;
        wait_start(n);
        check("restart_latency", 32'(n), 32'(PWRUP_CYC + 2));
        wait_done();
        @(negedge clk);
        check("run3_done", 32'(cfg_done), 32'(1));
        check("run3_starts", 32'(n_starts), 32'(exp_n));
        check("run3_q_empty", 32'(q.size()), 32'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
